// File: rtl/null_sink_checker_if.sv
// Stream port bundle for the null sink checker.
// master drives data/last/valid, slave returns ready.
interface null_sink_checker_if;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;

  modport master (
    output i_tdata,
    output i_tlast,
    output i_tvalid,
    input  i_tready
  );

  modport slave (
    input  i_tdata,
    input  i_tlast,
    input  i_tvalid,
    output i_tready
  );
endinterface

// File: rtl/null_sink_checker.sv
// Terminating stream consumer: throttled ready, packet/line counts,
// SID/length checks. Optional seq check: NULL_SINK_SEQ_CHECK_EN.
module null_sink_checker #(
  parameter int BASE  = 0,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_stb,
  input  logic [7:0]         set_addr,
  input  logic [31:0]        set_data,
  null_sink_checker_if.slave axis,
  input  logic               rb_addr,
  output logic [63:0]        rb_data,
  output logic               err
);

  typedef enum logic {HDR = 1'b0, PAY = 1'b1} state_t;

  state_t state, state_nxt;

  logic [31:0]      exp_sid;
  logic [LEN_W-1:0] exp_len;
  logic [15:0]      throttle;
  logic             enable;
  logic [15:0]      tc;

  logic [LEN_W-1:0] plen;
  logic [LEN_W:0]   plen_inc;

  logic [31:0] pkt_count;
  logic [31:0] line_count;
  logic [15:0] sid_err;
  logic [15:0] len_err;
  logic [15:0] seq_err;

  logic wr_sid, wr_len, wr_thr, wr_ctrl, clear;
  logic tready, beat;
  logic hdr_beat, pay_beat, pkt_inc;
  logic sid_hit, len_hit, seq_hit;

  assign wr_sid  = set_stb && (set_addr == 8'(BASE));
  assign wr_len  = set_stb && (set_addr == 8'(BASE + 1));
  assign wr_thr  = set_stb && (set_addr == 8'(BASE + 2));
  assign wr_ctrl = set_stb && (set_addr == 8'(BASE + 3));
  assign clear   = wr_ctrl && set_data[1];

  assign tready        = enable && (tc == 16'd0);
  assign axis.i_tready = tready;
  assign beat          = axis.i_tvalid && tready;

  assign plen_inc = {1'b0, plen} + {{LEN_W{1'b0}}, 1'b1};

  // Settings registers; clear bit is a pulse and is not stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_sid  <= '0;
      exp_len  <= '0;
      throttle <= '0;
      enable   <= 1'b0;
    end else begin
      if (wr_sid)  exp_sid  <= set_data;
      if (wr_len)  exp_len  <= set_data[LEN_W-1:0];
      if (wr_thr)  throttle <= set_data[15:0];
      if (wr_ctrl) enable   <= set_data[0];
    end
  end

  // Backpressure phase counter, 0..throttle, frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      tc <= '0;
    end else if (throttle == 16'd0) begin
      tc <= '0;
    end else if (enable) begin
      tc <= (tc >= throttle) ? 16'd0 : tc + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= state_nxt;
  end

  // FSM next state: header line opens a packet unless it is also last.
  always_comb begin
    state_nxt = state;
    if (beat) begin
      unique case (state)
        HDR:     if (!axis.i_tlast) state_nxt = PAY;
        PAY:     if (axis.i_tlast)  state_nxt = HDR;
        default: state_nxt = HDR;
      endcase
    end
  end

  // FSM outputs: per-beat increment and error strobes.
  always_comb begin
    hdr_beat = 1'b0;
    pay_beat = 1'b0;
    pkt_inc  = 1'b0;
    sid_hit  = 1'b0;
    len_hit  = 1'b0;
    if (beat) begin
      pkt_inc = axis.i_tlast;
      unique case (state)
        HDR: begin
          hdr_beat = 1'b1;
          sid_hit  = axis.i_tdata[31:0] != exp_sid;
          if (axis.i_tlast) len_hit = exp_len != '0;
        end
        PAY: begin
          pay_beat = 1'b1;
          if (axis.i_tlast) len_hit = plen_inc != {1'b0, exp_len};
        end
        default: ;
      endcase
    end
  end

  // Payload line counter for the packet in flight, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      plen <= '0;
    end else if (hdr_beat && !axis.i_tlast) begin
      plen <= '0;
    end else if (pay_beat && plen != '1) begin
      plen <= plen_inc[LEN_W-1:0];
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pkt_count  <= '0;
      line_count <= '0;
      sid_err    <= '0;
      len_err    <= '0;
    end else begin
      if (beat && line_count != '1)   line_count <= line_count + 32'd1;
      if (pkt_inc && pkt_count != '1) pkt_count  <= pkt_count + 32'd1;
      if (sid_hit && sid_err != '1)   sid_err    <= sid_err + 16'd1;
      if (len_hit && len_err != '1)   len_err    <= len_err + 16'd1;
    end
  end

`ifdef NULL_SINK_SEQ_CHECK_EN
  logic [11:0] exp_seq;
  logic [11:0] seq_fld;
  logic        seq_vld;
  logic        unused_bits;

  assign seq_fld     = axis.i_tdata[43:32];
  assign seq_hit     = hdr_beat && seq_vld && (seq_fld != exp_seq);
  assign unused_bits = ^axis.i_tdata[63:44];

  // Sequence tracker: first header after reset/clear only syncs.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      seq_vld <= 1'b0;
      exp_seq <= '0;
      seq_err <= '0;
    end else if (hdr_beat) begin
      seq_vld <= 1'b1;
      exp_seq <= seq_fld + 12'd1;
      if (seq_hit && seq_err != '1) seq_err <= seq_err + 16'd1;
    end
  end
`else
  logic unused_bits;

  assign seq_hit     = 1'b0;
  assign seq_err     = '0;
  assign unused_bits = ^axis.i_tdata[63:32];
`endif

  // Sticky error flag.
  always_ff @(posedge clk) begin
    if (reset || clear)                  err <= 1'b0;
    else if (sid_hit || len_hit || seq_hit) err <= 1'b1;
  end

  // Registered readback mux.
  always_ff @(posedge clk) begin
    if (reset)        rb_data <= '0;
    else if (rb_addr) rb_data <= {sid_err, len_err, seq_err, 14'd0, state, err};
    else              rb_data <= {line_count, pkt_count};
  end

endmodule

// File: tb/tb_null_sink_checker.sv
// Bench for null_sink_checker: packet-level model checked every cycle
// plus literal readback expectations.
module tb_null_sink_checker;
  localparam int BASE = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        rb_addr = 1'b0;
  logic [63:0] rb_data;
  logic        err;

  null_sink_checker_if axis();

  null_sink_checker #(.BASE(BASE), .LEN_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .set_stb(set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .axis(axis),
    .rb_addr(rb_addr),
    .rb_data(rb_data),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

`ifdef NULL_SINK_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  typedef struct {
    longint pkt, line, sid_err, len_err, seq_err;
    longint lines, thr, phase, len, seq_next;
    bit pay, err, en, seq_have;
    bit [31:0] sid;
    bit [63:0] rb;
  } mdl_t;

  mdl_t m = '{default: 0};

  function automatic longint sat(longint v, longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  function automatic bit m_rdy(mdl_t s);
    return s.en && (s.phase % (s.thr + 1) == 0);
  endfunction

  function automatic mdl_t step(mdl_t s);
    mdl_t n = s;
    bit hit = 1'b0;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    n.rb = rb_addr ?
      {16'(s.sid_err), 16'(s.len_err), 16'(s.seq_err), 14'd0, s.pay, s.err} :
      {32'(s.line), 32'(s.pkt)};
    if (axis.i_tvalid && m_rdy(s)) begin
      n.line = sat(s.line, 64'hFFFF_FFFF);
      if (!s.pay) begin
        n.lines = 1;
        if (axis.i_tdata[31:0] != s.sid) begin
          n.sid_err = sat(s.sid_err, 65535);
          hit = 1'b1;
        end
`ifdef NULL_SINK_SEQ_CHECK_EN
        begin
          longint f = longint'(axis.i_tdata[43:32]);
          if (s.seq_have && f != s.seq_next) begin
            n.seq_err = sat(s.seq_err, 65535);
            hit = 1'b1;
          end
          n.seq_have = 1'b1;
          n.seq_next = (f + 1) % 4096;
        end
`endif
      end else begin
        n.lines = s.lines + 1;
      end
      if (axis.i_tlast) begin
        n.pkt = sat(s.pkt, 64'hFFFF_FFFF);
        if (n.lines - 1 != s.len) begin
          n.len_err = sat(s.len_err, 65535);
          hit = 1'b1;
        end
        n.pay = 1'b0;
      end else begin
        n.pay = 1'b1;
      end
    end
    if (hit) n.err = 1'b1;
    if (s.en) n.phase = s.phase + 1;
    if (set_stb) begin
      if (set_addr == 8'(BASE)) n.sid = set_data;
      if (set_addr == 8'(BASE + 1)) n.len = longint'(set_data[15:0]);
      if (set_addr == 8'(BASE + 2)) begin
        n.thr = longint'(set_data[15:0]);
        n.phase = 0;
      end
      if (set_addr == 8'(BASE + 3)) begin
        n.en = set_data[0];
        if (set_data[1]) begin
          n.pkt = 0; n.line = 0; n.sid_err = 0;
          n.len_err = 0; n.seq_err = 0;
          n.err = 1'b0; n.seq_have = 1'b0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m);

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tready", 64'(axis.i_tready), 64'(m_rdy(m)));
      chk("err", 64'(err), 64'(m.err));
      chk("rb_data", rb_data, m.rb);
    end
  end

  bit cnt_on = 1'b0;
  int cyc = 0;
  int rdy_cnt = 0;

  always @(negedge clk) begin
    if (cnt_on) begin
      cyc <= cyc + 1;
      if (axis.i_tready) rdy_cnt <= rdy_cnt + 1;
    end
  end

  logic [11:0] seqn = 12'd0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic line(logic [63:0] d, logic last);
    int n = 0;
    bit rdy;
    axis.i_tdata = d;
    axis.i_tlast = last;
    axis.i_tvalid = 1'b1;
    do begin
      rdy = axis.i_tready;
      tick();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_total++;
      $display("FAIL line_timeout: got no beat want beat");
    end
  endtask

  task automatic pkt(logic [31:0] sid, int npay);
    line({20'd0, seqn, sid}, npay == 0);
    seqn++;
    for (int i = 1; i <= npay; i++) line(64'(i), i == npay);
    axis.i_tvalid = 1'b0;
    axis.i_tlast = 1'b0;
  endtask

  task automatic rb_chk(string name, bit a, logic [63:0] exp);
    rb_addr = a;
    tick();
    chk(name, rb_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    axis.i_tdata = '0;
    axis.i_tlast = 1'b0;
    axis.i_tvalid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_tready", 64'(axis.i_tready), 64'd0);
    chk("rst_rb", rb_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_on = 1'b1;

    // Full-rate streaming.
    wr(8'(BASE), 32'hDEADBEEF);
    wr(8'(BASE + 1), 32'd8);
    wr(8'(BASE + 2), 32'd0);
    wr(8'(BASE + 3), 32'd1);
    for (int i = 0; i < 10; i++) pkt(32'hDEADBEEF, 8);
    rb_chk("t1_rb0", 1'b0, {32'd90, 32'd10});
    rb_chk("t1_rb1", 1'b1, 64'd0);

    // Throttle 3: one ready cycle in four.
    wr(8'(BASE + 2), 32'd3);
    cnt_on = 1'b1;
    pkt(32'hDEADBEEF, 8);
    pkt(32'hDEADBEEF, 8);
    for (int g = 0; g < 200 && cyc < 72; g++) tick();
    cnt_on = 1'b0;
    chk("t2_ready_cycles", 64'(rdy_cnt), 64'd18);
    chk("t2_cycles", 64'(cyc), 64'd72);
    for (int g = 0; g < 8 && (m.phase % 4) != 3; g++) tick();
    wr(8'(BASE + 2), 32'd0);
    rb_chk("t2_rb0", 1'b0, {32'd108, 32'd12});

    // Length and SID errors.
    pkt(32'hDEADBEEF, 7);
    pkt(32'hDEADBEEF, 0);
    chk("t3_err", 64'(err), 64'd1);
    pkt(32'hCAFEF00D, 8);
    rb_chk("t3_rb0", 1'b0, {32'd126, 32'd15});
    rb_chk("t3_rb1", 1'b1, {16'd1, 16'd2, 16'd0, 14'd0, 1'b0, 1'b1});

    // Disable mid-packet, then resume.
    line({20'd0, seqn, 32'hDEADBEEF}, 1'b0);
    seqn++;
    for (int i = 1; i <= 4; i++) line(64'(i), 1'b0);
    axis.i_tvalid = 1'b0;
    wr(8'(BASE + 3), 32'd0);
    chk("t4_ready_off", 64'(axis.i_tready), 64'd0);
    axis.i_tdata = 64'd5;
    axis.i_tvalid = 1'b1;
    repeat (50) tick();
    rb_chk("t4_rb0_hold", 1'b0, {32'd131, 32'd15});
    rb_chk("t4_rb1_hold", 1'b1, {16'd1, 16'd2, 16'd0, 14'd0, 1'b1, 1'b1});
    wr(8'(BASE + 3), 32'd1);
    for (int i = 5; i <= 8; i++) line(64'(i), i == 8);
    axis.i_tvalid = 1'b0;
    axis.i_tlast = 1'b0;
    rb_chk("t4_rb0", 1'b0, {32'd135, 32'd16});
    rb_chk("t4_rb1", 1'b1, {16'd1, 16'd2, 16'd0, 14'd0, 1'b0, 1'b1});

    // Clear on the same edge as a tlast beat.
    rb_addr = 1'b0;
    line({20'd0, seqn, 32'hDEADBEEF}, 1'b0);
    seqn++;
    for (int i = 1; i <= 7; i++) line(64'(i), 1'b0);
    axis.i_tdata = 64'd8;
    axis.i_tlast = 1'b1;
    set_stb = 1'b1;
    set_addr = 8'(BASE + 3);
    set_data = 32'd3;
    tick();
    set_stb = 1'b0;
    axis.i_tvalid = 1'b0;
    axis.i_tlast = 1'b0;
    chk("t5_err", 64'(err), 64'd0);
    tick();
    chk("t5_rb0_clr", rb_data, 64'd0);
    pkt(32'hDEADBEEF, 8);
    rb_chk("t5_rb0", 1'b0, {32'd9, 32'd1});
    rb_chk("t5_rb1", 1'b1, 64'd0);

    // Sequence numbers 5,6,7,9,10.
    wr(8'(BASE + 3), 32'd3);
    seqn = 12'd5;
    for (int i = 0; i < 3; i++) pkt(32'hDEADBEEF, 8);
    seqn = 12'd9;
    for (int i = 0; i < 2; i++) pkt(32'hDEADBEEF, 8);
    rb_chk("t6_rb0", 1'b0, {32'd45, 32'd5});
    rb_chk("t6_rb1", 1'b1,
      {16'd0, 16'd0, 16'(SEQ), 14'd0, 1'b0, SEQ});

    tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/null_sink_checker.md
Name: null_sink_checker

Overview:
- Terminating consumer for the 64-bit AXI-stream output of the null packet source.
- Accepts packets under a programmable backpressure pattern and counts packets and lines.
- Checks each packet's header SID and payload length against programmed expectations and reports counts via a registered readback port.
- Used in rfnoc sims and on-chip loopback tests.

Parameters:
- BASE, 0, settings-bus base address; registers occupy BASE+0..BASE+3.
- LEN_W, 16, width of per-packet line counter and expected-length register.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- set_stb  input  1  settings write strobe.
- set_addr  input  8  settings address.
- set_data  input  32  settings data.
- i_tdata  input  64  stream data.
- i_tlast  input  1  last line of packet.
- i_tvalid  input  1  stream valid.
- i_tready  output  1  stream ready.
- rb_addr  input  1  readback select.
- rb_data  output  64  registered readback word.
- err  output  1  sticky: any SID/length (/seq) error since last clear.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Registers, all zero on reset:
  - BASE+0: exp_sid[31:0].
  - BASE+1: exp_len[LEN_W-1:0], the expected payload lines excluding the header.
  - BASE+2: throttle[15:0].
  - BASE+3: ctrl; bit0 = enable, bit1 = clear (self-clearing pulse, not stored).
- Reset values: i_tready=0, rb_data=0, err=0, all counters 0, FSM in HDR.
- Throttle counter tc:
  - throttle==0: tc held at 0.
  - Otherwise tc counts 0..throttle and wraps, advancing every cycle while enable=1.
- i_tready = enable & (tc==0). This is combinational from registers (no data path dependency).
- Beat: i_tvalid & i_tready. Only beats change state or counters.
- FSM HDR:
  - On a beat, line_count+=1.
  - If i_tdata[31:0]!=exp_sid, sid_err+=1.
  - If i_tlast: pkt_count+=1, and if exp_len!=0, len_err+=1; stay in HDR.
  - Else: plen=0 and go to PAY.
- FSM PAY:
  - On a beat, line_count+=1 and plen+=1 (saturating at all-ones).
  - If i_tlast: pkt_count+=1; if plen+1!=exp_len, len_err+=1; go to HDR.
- Counter widths: pkt_count 32b, line_count 32b, sid_err 16b, len_err 16b.
  - All saturate at all-ones; no wrap.
- err is set the cycle after any error increment and held until clear or reset.
- Clear pulse:
  - Zeroes counters and err on the next edge.
  - Clear takes priority over a simultaneous beat increment.
  - Does not change the FSM state or registers.
- Enable dropped mid-packet: i_tready=0 next cycle; FSM and plen are retained; the packet resumes when re-enabled.
- Register write during a packet: takes effect on the next edge; the check of the current packet uses the value at its tlast beat.
- Readback, registered, 1-cycle latency from rb_addr:
  - rb_addr=0: {line_count, pkt_count}.
  - rb_addr=1: {sid_err, len_err, seq_err, 14'b0, state, err}.

Optional Feature:
- Macro NULL_SINK_SEQ_CHECK_EN.
- When defined:
  - The header field i_tdata[43:32] is a 12-bit sequence number.
  - The first header after reset or clear loads exp_seq = field+1 (mod 4096) with no error.
  - Subsequent headers: if field!=exp_seq, seq_err+=1 (16b saturating) and err is set.
  - exp_seq always resyncs to field+1.
- When undefined: no sequence logic; the seq_err readback field reads 0.

Test Plan:
- Reset, then exp_sid=DEADBEEF, exp_len=8, throttle=0, enable=1; stream 10 packets of header SID DEADBEEF + 8 payload lines -> pkt_count=10, line_count=90, sid_err=0, len_err=0, err=0, i_tready high continuously.
- Same programming, throttle=3, with i_tvalid always high -> i_tready high exactly 1 cycle in 4; 2 packets take 72 cycles; counts 2/18.
- Packet with 7 payload lines, then packet with header-only tlast -> len_err=2, err=1; with header SID 0xCAFEF00D -> sid_err increments by 1.
- Enable=0 after 4 payload lines, hold 50 cycles, enable=1 and finish -> i_tready low within 1 cycle; no beats while disabled; packet completes with len_err unchanged.
- Clear written on the same cycle as a tlast beat -> pkt_count reads 0 two cycles later; err=0; the next packet counts as 1.
- With NULL_SINK_SEQ_CHECK_EN: sequence 5,6,7,9,10 -> seq_err=1. Without the macro: the field reads 0.
